nco_tune_ctrl: RTL and testbench

Tuning controller for the receiver's carrier NCO. Accepts ASCII commands from the UART receiver byte stream and sequences updates of the 64-bit NCO phase increment: direct hex load, preset station select, and ±1 kHz / ±9 kHz steps. Each command is answered with an ack byte to the UART transmitter. Sits between the UART RX/TX pair and the NCO phase-increment input, in the 136 MHz PLL clock domain.

---
 rtl/nco_tune_pkg.sv | 40 ++++
 rtl/ascii_hex_decode.sv | 22 ++
 rtl/nco_tune_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_nco_tune_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_tune_pkg.sv
// Shared types and constants for the NCO tuning controller.
package nco_tune_pkg;

    // Controller states; busy is derived from "not IDLE".
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEX,
        ST_SEL,
        ST_APPLY,
        ST_ACK
    } tune_state_t;

    // What APPLY does with the captured operand.
    typedef enum logic [1:0] {
        OP_LOAD,
        OP_ADD,
        OP_SUB
    } tune_op_t;

    // ASCII command characters.
    localparam logic [7:0] CH_LOAD   = 8'h50;  // 'P'
    localparam logic [7:0] CH_SEL    = 8'h53;  // 'S'
    localparam logic [7:0] CH_PLUS   = 8'h2B;  // '+'
    localparam logic [7:0] CH_MINUS  = 8'h2D;  // '-'
    localparam logic [7:0] CH_UP     = 8'h75;  // 'u'
    localparam logic [7:0] CH_DOWN   = 8'h64;  // 'd'

    // Ack bytes returned to the UART transmitter.
    localparam logic [7:0] ACK_OK  = 8'h4B;    // 'K'
    localparam logic [7:0] ACK_ERR = 8'h45;    // 'E'

    // Default tuning constants (136 MHz clock, 64-bit accumulator).
    localparam logic [63:0] DEF_STEP_FINE   = 64'h7B5CA45266E2;     // 1 kHz
    localparam logic [63:0] DEF_STEP_COARSE = 64'h45641C6E59DF0;    // 9 kHz
    localparam logic [63:0] DEF_PRESET0     = 64'h104376A9DD10437;  // 540 kHz
    localparam logic [63:0] DEF_PRESET1     = 64'h19C0268CF359C02;  // 855 kHz
    localparam logic [63:0] DEF_PRESET2     = 64'h1B1B1B1B1B1B1B1;  // 900 kHz
    localparam logic [63:0] DEF_PRESET3     = 64'h28EE0CC5170287A;  // 1359 kHz

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f'.
module ascii_hex_decode (
    input  logic [7:0] ascii,
    output logic [3:0] nibble,
    output logic       valid
);

    // Letters share the low nibble pattern 1..6, so add 9 to reach 10..15.
    always_comb begin
        nibble = 4'd0;
        valid  = 1'b0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            nibble = ascii[3:0];
            valid  = 1'b1;
        end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                     (ascii >= 8'h61 && ascii <= 8'h66)) begin
            nibble = ascii[3:0] + 4'd9;
            valid  = 1'b1;
        end
    end

endmodule

// File: rtl/nco_tune_ctrl.sv
// UART command sequencer for the carrier NCO phase increment.
//
// Handshake: rx_dv is a one-cycle strobe qualifying rx_byte; tx_dv is a
// one-cycle strobe qualifying tx_byte, issued only on an edge where
// tx_active was sampled low. inc_valid pulses for the cycle after phase_inc
// takes a new value.
module nco_tune_ctrl
    import nco_tune_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 13_600_000,
    parameter logic [63:0] STEP_FINE      = DEF_STEP_FINE,
    parameter logic [63:0] STEP_COARSE    = DEF_STEP_COARSE,
    parameter logic [63:0] PRESET0        = DEF_PRESET0,
    parameter logic [63:0] PRESET1        = DEF_PRESET1,
    parameter logic [63:0] PRESET2        = DEF_PRESET2,
    parameter logic [63:0] PRESET3        = DEF_PRESET3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    input  logic        tx_active,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    output logic [63:0] phase_inc,
    output logic        inc_valid,
    output logic        busy
);

    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

    tune_state_t      state, next_state;
    tune_op_t         op, op_d;
    logic [63:0]      operand, operand_d;   // hex shadow, preset or step
    logic [3:0]       nib_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             ack_err;
    logic             ld_operand, nib_inc, err_set, apply_en, tx_fire;
    logic             in_cmd, timeout, sub_mode;
    logic [3:0]       hex_nib;
    logic             hex_ok;
    logic [64:0]      addend, sum;

    ascii_hex_decode u_hex (
        .ascii  (rx_byte),
        .nibble (hex_nib),
        .valid  (hex_ok)
    );

    // Single 65-bit add/subtract; bit 64 is carry-out for '+' and borrow
    // (phase_inc < step) for '-'.
    assign sub_mode = (op == OP_SUB);
    assign addend   = sub_mode ? ~{1'b0, operand} : {1'b0, operand};
    assign sum      = {1'b0, phase_inc} + addend + {64'd0, sub_mode};

    assign in_cmd  = (state == ST_HEX) || (state == ST_SEL);
    assign timeout = in_cmd && !rx_dv && (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        next_state = state;
        op_d       = OP_LOAD;
        operand_d  = '0;
        ld_operand = 1'b0;
        nib_inc    = 1'b0;
        err_set    = 1'b0;
        apply_en   = 1'b0;
        tx_fire    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rx_dv) begin
                    case (rx_byte)
                        CH_LOAD: begin
                            next_state = ST_HEX;
                            ld_operand = 1'b1;
                        end
                        CH_SEL: next_state = ST_SEL;
                        CH_PLUS: begin
                            next_state = ST_APPLY;
                            ld_operand = 1'b1;
                            op_d       = OP_ADD;
                            operand_d  = STEP_COARSE;
                        end
                        CH_MINUS: begin
                            next_state = ST_APPLY;
                            ld_operand = 1'b1;
                            op_d       = OP_SUB;
                            operand_d  = STEP_COARSE;
                        end
                        CH_UP: begin
                            next_state = ST_APPLY;
                            ld_operand = 1'b1;
                            op_d       = OP_ADD;
                            operand_d  = STEP_FINE;
                        end
                        CH_DOWN: begin
                            next_state = ST_APPLY;
                            ld_operand = 1'b1;
                            op_d       = OP_SUB;
                            operand_d  = STEP_FINE;
                        end
                        default: ;
                    endcase
                end
            end
            ST_HEX: begin
                if (rx_dv) begin
                    if (hex_ok) begin
                        ld_operand = 1'b1;
                        operand_d  = {operand[59:0], hex_nib};
                        nib_inc    = 1'b1;
                        if (nib_cnt == 4'd15) next_state = ST_APPLY;
                    end else begin
                        next_state = ST_ACK;
                        err_set    = 1'b1;
                    end
                end else if (timeout) begin
                    next_state = ST_ACK;
                    err_set    = 1'b1;
                end
            end
            ST_SEL: begin
                if (rx_dv) begin
                    if (rx_byte[7:2] == 6'b001100) begin
                        next_state = ST_APPLY;
                        ld_operand = 1'b1;
                        case (rx_byte[1:0])
                            2'd0:    operand_d = PRESET0;
                            2'd1:    operand_d = PRESET1;
                            2'd2:    operand_d = PRESET2;
                            default: operand_d = PRESET3;
                        endcase
                    end else begin
                        next_state = ST_ACK;
                        err_set    = 1'b1;
                    end
                end else if (timeout) begin
                    next_state = ST_ACK;
                    err_set    = 1'b1;
                end
            end
            ST_APPLY: begin
                apply_en   = 1'b1;
                next_state = ST_ACK;
            end
            ST_ACK: begin
                if (!tx_active) begin
                    tx_fire    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Datapath: operand shadow, counters, phase increment and ack outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_inc <= PRESET0;
            inc_valid <= 1'b0;
            tx_dv     <= 1'b0;
            tx_byte   <= ACK_OK;
            busy      <= 1'b0;
            op        <= OP_LOAD;
            operand   <= '0;
            nib_cnt   <= '0;
            gap_cnt   <= '0;
            ack_err   <= 1'b0;
        end else begin
            inc_valid <= 1'b0;
            tx_dv     <= tx_fire;
            busy      <= (next_state != ST_IDLE) || tx_fire;
            if (ld_operand) begin
                operand <= operand_d;
                op      <= op_d;
            end
            if (state == ST_IDLE)  nib_cnt <= '0;
            else if (nib_inc)      nib_cnt <= nib_cnt + 4'd1;
            if (rx_dv || !in_cmd)  gap_cnt <= '0;
            else                   gap_cnt <= gap_cnt + 1'b1;
            if (err_set) ack_err <= 1'b1;
            if (apply_en) begin
                if (op != OP_LOAD && sum[64]) begin
                    ack_err <= 1'b1;
                end else begin
                    ack_err   <= 1'b0;
                    phase_inc <= (op == OP_LOAD) ? operand : sum[63:0];
                    inc_valid <= 1'b1;
                end
            end
            if (tx_fire) tx_byte <= ack_err ? ACK_ERR : ACK_OK;
        end
    end

endmodule

// File: tb/tb_nco_tune_ctrl.sv
// Bench for nco_tune_ctrl: directed vector table, multi-cycle corner
// sequences and randomized commands against an arithmetic reference model.
module tb_nco_tune_ctrl;

    localparam int          TO      = 100;
    localparam logic [63:0] FINE    = 64'h7B5CA45266E2;
    localparam logic [63:0] COARSE  = 64'h45641C6E59DF0;
    localparam logic [63:0] PRE0    = 64'h104376A9DD10437;
    localparam logic [63:0] PRE1    = 64'h19C0268CF359C02;
    localparam logic [63:0] PRE2    = 64'h1B1B1B1B1B1B1B1;
    localparam logic [63:0] PRE3    = 64'h28EE0CC5170287A;
    localparam logic [7:0]  K_ACK   = 8'h4B;
    localparam logic [7:0]  E_ACK   = 8'h45;

    typedef struct {
        string       cmd;
        logic [7:0]  ack;
        logic [63:0] pi;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         checks    = 0;
    int         errors    = 0;
    int         ack_count = 0;
    int         inc_count = 0;
    logic       inc_prev  = 1'b0;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        rx_dv     = 1'b0;
    logic [7:0]  rx_byte   = 8'h00;
    logic        tx_active = 1'b0;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic [63:0] phase_inc;
    logic        inc_valid;
    logic        busy;

    nco_tune_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte),
        .tx_active (tx_active),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .phase_inc (phase_inc),
        .inc_valid (inc_valid),
        .busy      (busy)
    );

    // Clock.
    initial forever #5 clk = ~clk;

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack byte must match the oldest expected one,
    // and inc_valid must never be wider than one cycle.
    always @(negedge clk) begin
        logic [7:0] eb;
        if (!reset) begin
            if (tx_dv) begin
                ack_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got tx_byte=%h with none expected", tx_byte);
                end else begin
                    eb = exp_q.pop_front();
                    check("ack_byte", 64'(tx_byte), 64'(eb));
                end
            end
            if (inc_valid) begin
                inc_count++;
                check("inc_width", 64'(inc_prev), 64'd0);
            end
            inc_prev = inc_valid;
        end else begin
            inc_prev = 1'b0;
        end
    end

    // Driver: present one byte for exactly one clock; call at a negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Send a command, wait (bounded) for its ack, then check phase_inc and
    // the number of inc_valid pulses it produced.
    task automatic run_cmd(input string cmd, input logic [7:0] exp_ack,
                           input logic [63:0] exp_pi, input int hold_in);
        int acks0, incs0, waited, hold;
        hold  = hold_in;
        acks0 = ack_count;
        incs0 = inc_count;
        exp_q.push_back(exp_ack);
        tx_active = (hold > 0);
        send_str(cmd);
        waited = 0;
        while (ack_count == acks0 && waited < 300) begin
            @(negedge clk);
            waited++;
            if (hold > 0) hold--;
            else          tx_active = 1'b0;
        end
        tx_active = 1'b0;
        check({"ack_seen ", cmd}, 64'(ack_count - acks0), 64'd1);
        @(negedge clk);
        check({"phase_inc ", cmd}, phase_inc, exp_pi);
        check({"inc_pulses ", cmd}, 64'(inc_count - incs0), (exp_ack == K_ACK) ? 64'd1 : 64'd0);
    endtask

    task automatic add_vec(input string c, input logic [7:0] a, input logic [63:0] p);
        vec_t v;
        v.cmd = c;
        v.ack = a;
        v.pi  = p;
        vecs.push_back(v);
    endtask

    function automatic string hex_cmd(input logic [63:0] v);
        string      s;
        logic [3:0] n;
        logic [7:0] ch;
        s = "P";
        for (int i = 15; i >= 0; i--) begin
            n = v[i*4 +: 4];
            if (n < 4'd10) ch = 8'h30 + {4'd0, n};
            else           ch = (($urandom_range(0, 1) == 0) ? 8'h41 : 8'h61) + {4'd0, n} - 8'd10;
            s = $sformatf("%s%c", s, ch);
        end
        return s;
    endfunction

    function automatic logic [63:0] preset(input int i);
        case (i)
            0:       return PRE0;
            1:       return PRE1;
            2:       return PRE2;
            default: return PRE3;
        endcase
    endfunction

    initial begin
        logic [63:0] m, v;
        logic [64:0] wide;
        logic [7:0]  ea, bad;
        string       s;
        int          kind, hold, idx, lat, acks0, seen;
        logic [7:0]  bad_hex[6];
        logic [7:0]  bad_sel[4];
        bad_hex = '{8'h47, 8'h67, 8'h2F, 8'h3A, 8'h40, 8'h60};  // G g / : @ `
        bad_sel = '{8'h34, 8'h39, 8'h78, 8'h2F};                // 4 9 x /

        // Reset.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_phase_inc", phase_inc, PRE0);
        check("rst_tx_dv", 64'(tx_dv), 64'd0);
        check("rst_inc_valid", 64'(inc_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tx_byte", 64'(tx_byte), 64'(K_ACK));

        // "S3" with cycle-exact timing.
        exp_q.push_back(K_ACK);
        send_byte("S");
        check("s3_busy_sel", 64'(busy), 64'd1);
        send_byte("3");
        check("s3_pi_before", phase_inc, PRE0);
        @(negedge clk);
        check("s3_inc_valid", 64'(inc_valid), 64'd1);
        check("s3_pi_after", phase_inc, PRE3);
        @(negedge clk);
        check("s3_inc_low", 64'(inc_valid), 64'd0);
        check("s3_tx_dv", 64'(tx_dv), 64'd1);
        check("s3_tx_byte", 64'(tx_byte), 64'(K_ACK));
        check("s3_busy_tx", 64'(busy), 64'd1);
        @(negedge clk);
        check("s3_tx_dv_low", 64'(tx_dv), 64'd0);
        check("s3_busy_done", 64'(busy), 64'd0);

        // Directed vector table.
        add_vec("P00000000000000ff", K_ACK, 64'hFF);
        add_vec("P12G", E_ACK, 64'hFF);
        add_vec("S0", K_ACK, PRE0);
        add_vec("+", K_ACK, PRE0 + COARSE);
        add_vec("d", K_ACK, PRE0 + COARSE - FINE);
        add_vec("P0000000000000010", K_ACK, 64'h10);
        add_vec("-", E_ACK, 64'h10);
        add_vec("d", E_ACK, 64'h10);
        add_vec("PFFFFFFFFFFFFFFFF", K_ACK, '1);
        add_vec("u", E_ACK, '1);
        add_vec("+", E_ACK, '1);
        add_vec("S4", E_ACK, '1);
        add_vec("S2", K_ACK, PRE2);
        add_vec(hex_cmd(COARSE), K_ACK, COARSE);
        add_vec("-", K_ACK, 64'd0);
        add_vec(hex_cmd(64'd0 - COARSE), K_ACK, 64'd0 - COARSE);
        add_vec("+", E_ACK, 64'd0 - COARSE);
        add_vec("-", K_ACK, 64'd0 - COARSE - COARSE);
        add_vec("Pabcdef0123456789", K_ACK, 64'hABCDEF0123456789);
        add_vec("P0000000000000001", K_ACK, 64'h1);
        add_vec("PABCDEF0123456789", K_ACK, 64'hABCDEF0123456789);
        add_vec("P:", E_ACK, 64'hABCDEF0123456789);
        for (int i = 0; i < vecs.size(); i++)
            run_cmd(vecs[i].cmd, vecs[i].ack, vecs[i].pi, 0);

        // Timeout after 5 digits; error ack TO+1 cycles after the last byte.
        exp_q.push_back(E_ACK);
        send_str("P12345");
        lat = 0;
        while (!tx_dv && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check("timeout_latency", 64'(lat), 64'(TO + 1));
        check("timeout_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("timeout_pi", phase_inc, 64'hABCDEF0123456789);
        check("timeout_idle", 64'(busy), 64'd0);
        run_cmd("S1", K_ACK, PRE1, 0);

        // A byte arriving on the timeout cycle wins.
        send_byte("P");
        repeat (TO - 1) @(negedge clk);
        run_cmd("0123456789abcdef", K_ACK, 64'h0123456789ABCDEF, 0);

        // Ack held off by tx_active; a byte sent during ACK is dropped.
        exp_q.push_back(K_ACK);
        tx_active = 1'b1;
        send_str("S2");
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) send_byte("+");
            else         @(negedge clk);
            if (tx_dv) seen++;
        end
        check("hold_no_tx", 64'(seen), 64'd0);
        tx_active = 1'b0;
        @(negedge clk);
        check("hold_release_tx", 64'(tx_dv), 64'd1);
        @(negedge clk);
        check("hold_tx_width", 64'(tx_dv), 64'd0);
        check("hold_pi", phase_inc, PRE2);

        // Reset in the middle of a load: no ack, back to PRESET0.
        acks0 = ack_count;
        send_str("P12");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_ack", 64'(ack_count - acks0), 64'd0);
        check("midrst_pi", phase_inc, PRE0);
        check("midrst_busy", 64'(busy), 64'd0);

        // Randomized commands against the arithmetic model.
        m = PRE0;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 7);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
            if ($urandom_range(0, 4) == 0) send_byte("z");  // ignored in IDLE
            case (kind)
                0, 2: begin
                    s = (kind == 0) ? "+" : "u";
                    wide = {1'b0, m} + {1'b0, (kind == 0) ? COARSE : FINE};
                    if (wide[64]) ea = E_ACK;
                    else begin
                        ea = K_ACK;
                        m  = wide[63:0];
                    end
                end
                1, 3: begin
                    s = (kind == 1) ? "-" : "d";
                    v = (kind == 1) ? COARSE : FINE;
                    if (m < v) ea = E_ACK;
                    else begin
                        ea = K_ACK;
                        m  = m - v;
                    end
                end
                4: begin
                    idx = $urandom_range(0, 3);
                    s   = $sformatf("S%0d", idx);
                    m   = preset(idx);
                    ea  = K_ACK;
                end
                5: begin
                    case ($urandom_range(0, 2))
                        0:       v = {$urandom, $urandom};
                        1:       v = 64'($urandom_range(0, 1 << 20));
                        default: v = ~64'($urandom_range(0, 1 << 20));
                    endcase
                    s  = hex_cmd(v);
                    m  = v;
                    ea = K_ACK;
                end
                6: begin
                    bad = bad_sel[$urandom_range(0, 3)];
                    s   = $sformatf("S%c", bad);
                    ea  = E_ACK;
                end
                default: begin
                    idx = $urandom_range(0, 15);
                    bad = bad_hex[$urandom_range(0, 5)];
                    s   = hex_cmd({$urandom, $urandom});
                    s   = $sformatf("%s%c", s.substr(0, idx), bad);
                    ea  = E_ACK;
                end
            endcase
            run_cmd(s, ea, m, hold);
        end

        repeat (5) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
